// File: rtl/fpu_normalize_seq.sv
// Multi-cycle mantissa normalizer: leading-one detect, then bounded left shifts
// with exponent adjustment and a clamp at the exponent floor (denormal result).
module fpu_normalize_seq #(
  parameter int WIDTH     = 32,
  parameter int EXP_W     = 8,
  parameter int STEP_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_denorm,
  output logic             busy
);

  localparam int LZ_W  = $clog2(WIDTH);
  localparam int STEP  = 1 << STEP_LOG2;
  localparam int CMP_W = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds with stable data until that edge.
  typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] mant_r;
  logic [EXP_W-1:0] exp_r;
  logic [EXP_W-1:0] exp_fin_r;
  logic             sign_r;
  logic             denorm_r;
  logic [LZ_W-1:0]  rem_r;

  function automatic logic [LZ_W-1:0] first_bit_position(input logic [WIDTH-1:0] v);
    logic [LZ_W-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) p = LZ_W'(i);
    return p;
  endfunction

  logic [LZ_W-1:0]  pos;
  logic [LZ_W-1:0]  lz;
  logic [EXP_W-1:0] limit;
  logic             clamp;
  logic [LZ_W-1:0]  det_rem;
  logic [EXP_W-1:0] det_exp;

  always_comb begin
    pos     = first_bit_position(mant_r);
    lz      = LZ_W'(WIDTH - 1) - pos;
    limit   = (exp_r == '0) ? '0 : exp_r - EXP_W'(1);
    clamp   = CMP_W'(lz) > CMP_W'(limit);
    det_rem = clamp ? LZ_W'(limit) : lz;
    det_exp = clamp ? '0 : exp_r - EXP_W'(lz);
  end

  // Small shifter: only distances 0..STEP exist, selected by an explicit mux.
  logic [LZ_W-1:0]  step;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    step    = (CMP_W'(rem_r) > CMP_W'(STEP)) ? LZ_W'(STEP) : rem_r;
    shifted = mant_r;
    for (int s = 0; s <= STEP; s++)
      if (int'(step) == s) shifted = mant_r << s;
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mant_r     <= '0;
      exp_r      <= '0;
      exp_fin_r  <= '0;
      sign_r     <= 1'b0;
      denorm_r   <= 1'b0;
      rem_r      <= '0;
      out_valid  <= 1'b0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mant_r <= in_mant;
            exp_r  <= in_exp;
            sign_r <= in_sign;
            state  <= DETECT;
          end
        end
        DETECT: begin
          if (mant_r == '0) begin
            out_mant   <= '0;
            out_exp    <= '0;
            out_zero   <= 1'b1;
            out_denorm <= 1'b0;
            out_sign   <= sign_r;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            exp_fin_r <= det_exp;
            denorm_r  <= clamp;
            rem_r     <= det_rem;
            if (det_rem == '0) begin
              out_mant   <= mant_r;
              out_exp    <= det_exp;
              out_zero   <= 1'b0;
              out_denorm <= clamp;
              out_sign   <= sign_r;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          mant_r <= shifted;
          rem_r  <= rem_r - step;
          if (rem_r == step) begin
            out_mant   <= shifted;
            out_exp    <= exp_fin_r;
            out_zero   <= 1'b0;
            out_denorm <= denorm_r;
            out_sign   <= sign_r;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_normalize_seq.sv
// Directed bench for fpu_normalize_seq (WIDTH=32, EXP_W=8, STEP_LOG2=3).
module tb_fpu_normalize_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_denorm;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fpu_normalize_seq #(.WIDTH(32), .EXP_W(8), .STEP_LOG2(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_zero(out_zero), .out_denorm(out_denorm), .busy(busy)
  );

  always #5 clk = ~clk;

  // Returns #1 after the accepting edge.
  task automatic send_op(input logic [31:0] m, input logic [7:0] e, input logic s);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_mant = m; in_exp = e; in_sign = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accepting edge as 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_mant = '0; in_exp = '0; in_sign = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_valid_busy: got %b/%b want 0/0", out_valid, busy); end
    checks++; if ({out_mant, out_exp, out_sign, out_zero, out_denorm} !== 43'd0) begin errors++; $display("FAIL rst_outs: got %h %h %b%b%b want all 0", out_mant, out_exp, out_sign, out_zero, out_denorm); end
  endtask

  task automatic test_normalized();
    int lat;
    send_op(32'h8000_0000, 8'd100, 1'b0);
    wait_out(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL norm_latency: got %0d want 2", lat); end
    checks++; if (out_mant !== 32'h8000_0000 || out_exp !== 8'd100) begin errors++; $display("FAIL norm_result: got %h/%0d want 80000000/100", out_mant, out_exp); end
    checks++; if (out_zero !== 1'b0 || out_denorm !== 1'b0 || out_sign !== 1'b0) begin errors++; $display("FAIL norm_flags: got z%b d%b s%b want 000", out_zero, out_denorm, out_sign); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL norm_release: got v%b r%b want v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_full_shift();
    int lat;
    send_op(32'h0000_0001, 8'd100, 1'b1);
    wait_out(lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL full_latency: got %0d want 6", lat); end
    checks++; if (out_mant !== 32'h8000_0000 || out_exp !== 8'd69) begin errors++; $display("FAIL full_result: got %h/%0d want 80000000/69", out_mant, out_exp); end
    checks++; if (out_denorm !== 1'b0 || out_sign !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL full_flags: got d%b s%b b%b want d0 s1 b1", out_denorm, out_sign, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_denorm();
    int lat;
    send_op(32'h0001_0000, 8'd10, 1'b0);
    wait_out(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL denorm_latency: got %0d want 4", lat); end
    checks++; if (out_mant !== 32'h0200_0000 || out_exp !== 8'd0) begin errors++; $display("FAIL denorm_result: got %h/%0d want 02000000/0", out_mant, out_exp); end
    checks++; if (out_denorm !== 1'b1 || out_zero !== 1'b0) begin errors++; $display("FAIL denorm_flags: got d%b z%b want d1 z0", out_denorm, out_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat;
    send_op(32'h0, 8'd55, 1'b1);
    wait_out(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", lat); end
    checks++; if (out_mant !== 32'h0 || out_exp !== 8'd0) begin errors++; $display("FAIL zero_result: got %h/%0d want 0/0", out_mant, out_exp); end
    checks++; if (out_zero !== 1'b1 || out_sign !== 1'b1 || out_denorm !== 1'b0) begin errors++; $display("FAIL zero_flags: got z%b s%b d%b want z1 s1 d0", out_zero, out_sign, out_denorm); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send_op(32'h0000_0001, 8'd100, 1'b0);
    wait_out(lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL bp_latency: got %0d want 6", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_mant = 32'h8000_0000; in_exp = 8'd3; in_sign = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_mant !== 32'h8000_0000 || out_exp !== 8'd69 || out_sign !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v%b %h/%0d s%b r%b want v1 80000000/69 s0 r0", i, out_valid, out_mant, out_exp, out_sign, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v%b r%b want v0 r1", out_valid, in_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_op: got b%b v%b want b0 v0", busy, out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    send_op(32'h0000_0001, 8'd100, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ctrl: got b%b v%b r%b want b0 v0 r1", busy, out_valid, in_ready); end
    checks++; if ({out_mant, out_exp, out_sign, out_zero, out_denorm} !== 43'd0) begin errors++; $display("FAIL midrst_outs: got %h %h %b%b%b want all 0", out_mant, out_exp, out_sign, out_zero, out_denorm); end
    send_op(32'h8000_0000, 8'd100, 1'b0);
    wait_out(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL midrst_latency: got %0d want 2", lat); end
    checks++; if (out_mant !== 32'h8000_0000 || out_exp !== 8'd100 || out_sign !== 1'b0) begin errors++; $display("FAIL midrst_result: got %h/%0d s%b want 80000000/100 s0", out_mant, out_exp, out_sign); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_normalized();
    test_full_shift();
    test_denorm();
    test_zero();
    test_backpressure();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
